dff_pair_sequencer: RTL
=======================

Name: dff_pair_sequencer

Overview:
- Command-driven sequencer for a dual D flip-flop device under test (74LS74-style: active-low PRE/CLR, rising-edge CLK, Q/Qb outputs).
- Per command, it drives one channel through a setup, pulse and settle sequence, then samples Q/Qb and compares them with the device truth table.
- Sits between the host/stimulus logic and the emulated (or physical) IC pins.
- Keeps saturating pass/fail tallies for board self-test.

Parameters:
- SETUP_CYC, 2, cycles D is held stable before the pulse (min 1)
- PULSE_CYC, 2, cycles CLK is high or PRE/CLR is low (min 1)
- SETTLE_CYC, 2, cycles after pulse release before sampling (min 1)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  sequencer idle, will accept command
- CMD_OP  in  2  0=PRESET, 1=CLEAR, 2=LOAD (clock D in), 3=BOTH (PRE and CLR low together)
- CMD_SEL  in  1  0=channel 1, 1=channel 2
- CMD_D  in  1  data for LOAD
- PRE_1, CLR_1, D_1, CLK_1  out  1 each  channel 1 pin drive
- PRE_2, CLR_2, D_2, CLK_2  out  1 each  channel 2 pin drive
- Q_1, Q_1b, Q_2, Q_2b  in  1 each  DUT outputs
- RES_VALID  out  1  one-cycle result strobe
- RES_PASS  out  1  sampled Q/Qb matched expected
- RES_Q  out  2  sampled {Qb,Q} of selected channel
- PASS_CNT  out  8  saturating pass count
- FAIL_CNT  out  8  saturating fail count

Behaviour:
- Everything is registered and updates on the CLK rising edge. RST is sampled on CLK only.
- Reset values:
  - PRE_x=1, CLR_x=1, CLK_x=0, D_x=0
  - RES_VALID=0, RES_PASS=0, RES_Q=0
  - PASS_CNT=0, FAIL_CNT=0
  - CMD_READY=0 while RST is high, 1 from the first edge after RST is released
- Idle pin levels: PRE=1, CLR=1, CLK=0. D_x holds its last value.
- FSM states: IDLE, SETUP, PULSE, SETTLE, CHECK.
- IDLE:
  - CMD_READY=1.
  - A command is accepted when CMD_VALID and CMD_READY are both high.
  - On acceptance, CMD_OP, CMD_SEL and CMD_D are latched; go to SETUP.
  - CMD_READY drops on the edge after acceptance.
- SETUP:
  - Lasts SETUP_CYC cycles.
  - For LOAD, the selected D_x is driven to the latched D. Other ops leave D_x unchanged.
- PULSE:
  - Lasts PULSE_CYC cycles.
  - LOAD: CLK_x=1. PRESET: PRE_x=0. CLEAR: CLR_x=0. BOTH: PRE_x=0 and CLR_x=0.
- SETTLE:
  - Lasts SETTLE_CYC cycles.
  - Pins return to idle levels; D_x is held.
- CHECK:
  - Lasts 1 cycle. Samples {Qb,Q} of the selected channel into RES_Q.
  - Expected {Qb,Q}: PRESET=01, CLEAR=10, LOAD={~D,D}, BOTH=11.
  - RES_PASS is set to (sampled == expected).
  - Exactly one of PASS_CNT/FAIL_CNT increments; each saturates at 255.
  - Next state is IDLE.
- Result timing:
  - RES_VALID is high for exactly one cycle, together with CMD_READY=1, in the first IDLE cycle.
  - Latency from the accept edge to RES_VALID high = SETUP_CYC+PULSE_CYC+SETTLE_CYC+1 cycles; 7 with defaults.
  - A new command may be accepted in that same cycle (back-to-back).
- RES_Q and RES_PASS hold their values until the next CHECK.
- The unselected channel's pins never change during a command.
- CMD inputs are ignored outside IDLE; no queueing.
- Reset mid-command:
  - The sequence aborts and pins return to reset levels on that edge.
  - No RES_VALID is issued and counters are cleared.
- Q inputs are assumed synchronous to CLK (emulated DUT). No synchronizer is included.

Test Plan:
- Reset, release, then PRESET on ch1 with DUT connected → RES_VALID 7 cycles after accept, RES_Q=01, RES_PASS=1, PASS_CNT=1; PRE_1 low for exactly 2 cycles; ch2 pins static.
- CLEAR ch2, then LOAD ch2 D=1, then LOAD ch2 D=0, back-to-back with CMD_VALID held high → RES_Q sequence 10, 01, 10, all pass, PASS_CNT=3; each CLK_2 high pulse is 2 cycles.
- BOTH on ch1 → PRE_1 and CLR_1 low together for 2 cycles; RES_Q=11, RES_PASS=1.
- Fault injection: Q_1 stuck at 0, then PRESET ch1 → RES_PASS=0, FAIL_CNT=1, PASS_CNT unchanged.
- 300 failing commands → FAIL_CNT saturates at 255 and does not wrap.
- Assert RST during the PULSE state of a LOAD → next edge has CLK_1=0, PRE/CLR=1, D_1=0, counters 0, no RES_VALID; CMD_READY=1 one cycle after RST release.

Source files
------------

// File: rtl/dff_pair_sequencer.sv
// dff_pair_sequencer: drives PRE/CLR/D/CLK of a dual D flip-flop per command and checks Q/Qb against the truth table
module dff_pair_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic       CMD_SEL,
    input  logic       CMD_D,
    output logic       PRE_1,
    output logic       CLR_1,
    output logic       D_1,
    output logic       CLK_1,
    output logic       PRE_2,
    output logic       CLR_2,
    output logic       D_2,
    output logic       CLK_2,
    input  logic       Q_1,
    input  logic       Q_1b,
    input  logic       Q_2,
    input  logic       Q_2b,
    output logic       RES_VALID,
    output logic       RES_PASS,
    output logic [1:0] RES_Q,
    output logic [7:0] PASS_CNT,
    output logic [7:0] FAIL_CNT
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, CHECK} state_t;
    localparam logic [1:0]  OP_PRESET   = 2'd0;
    localparam logic [1:0]  OP_CLEAR    = 2'd1;
    localparam logic [1:0]  OP_LOAD     = 2'd2;
    localparam logic [1:0]  OP_BOTH     = 2'd3;
    localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYC - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  op_r;
    logic        sel_r;
    logic        d_r;
    logic [1:0]  pre;
    logic [1:0]  clr;
    logic [1:0]  d;
    logic [1:0]  ck;
    logic [1:0]  q_sel;
    logic [1:0]  exp_q;
    assign {PRE_2, PRE_1} = pre;
    assign {CLR_2, CLR_1} = clr;
    assign {D_2, D_1}     = d;
    assign {CLK_2, CLK_1} = ck;
    // selected channel's sampled {Qb,Q} and the truth-table value it should show
    always_comb begin
        q_sel = sel_r ? {Q_2b, Q_2} : {Q_1b, Q_1};
        exp_q = (op_r == OP_PRESET) ? 2'b01 :
                (op_r == OP_CLEAR)  ? 2'b10 :
                (op_r == OP_LOAD)   ? {~d_r, d_r} : 2'b11;
    end
    // command sequencer: accept, setup D, pulse, settle, then sample and tally
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            op_r      <= '0;
            sel_r     <= 1'b0;
            d_r       <= 1'b0;
            pre       <= 2'b11;
            clr       <= 2'b11;
            d         <= 2'b00;
            ck        <= 2'b00;
            CMD_READY <= 1'b0;
            RES_VALID <= 1'b0;
            RES_PASS  <= 1'b0;
            RES_Q     <= 2'b00;
            PASS_CNT  <= '0;
            FAIL_CNT  <= '0;
        end else begin
            RES_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        op_r      <= CMD_OP;
                        sel_r     <= CMD_SEL;
                        d_r       <= CMD_D;
                        cnt       <= '0;
                        CMD_READY <= 1'b0;
                        state     <= SETUP;
                        if (CMD_OP == OP_LOAD) d[CMD_SEL] <= CMD_D;
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt         <= '0;
                        state       <= PULSE;
                        ck[sel_r]   <= (op_r == OP_LOAD);
                        pre[sel_r]  <= !(op_r == OP_PRESET || op_r == OP_BOTH);
                        clr[sel_r]  <= !(op_r == OP_CLEAR || op_r == OP_BOTH);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        cnt   <= '0;
                        state <= SETTLE;
                        pre   <= 2'b11;
                        clr   <= 2'b11;
                        ck    <= 2'b00;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CHECK: begin
                    RES_Q     <= q_sel;
                    RES_PASS  <= (q_sel == exp_q);
                    RES_VALID <= 1'b1;
                    CMD_READY <= 1'b1;
                    state     <= IDLE;
                    if (q_sel == exp_q) begin
                        if (PASS_CNT != 8'hFF) PASS_CNT <= PASS_CNT + 8'd1;
                    end else begin
                        if (FAIL_CNT != 8'hFF) FAIL_CNT <= FAIL_CNT + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
